// File: rtl/mine_placer.sv
// Sequential mine-field generator: clears a ROWS x COLS map on start, then places the requested
// number of mines at LFSR-chosen cells, one per cycle at most, never on the protected cell.
module mine_placer #(
    parameter int unsigned       ROWS      = 8,
    parameter int unsigned       COLS      = 8,
    parameter int unsigned       CNT_W     = 7,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned       REJ_MAX   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        bomb_count,
    input  logic                    safe_en,
    input  logic [$clog2(ROWS)-1:0] safe_row,
    input  logic [$clog2(COLS)-1:0] safe_col,
    output logic                    busy,
    output logic                    done,
    output logic                    clipped,
    output logic [CNT_W-1:0]        bombs_placed,
    output logic [ROWS*COLS-1:0]    mine_map
);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned REJ_W = $clog2(REJ_MAX + 1);
    localparam logic [REJ_W-1:0] REJ_LIM = REJ_W'(REJ_MAX);

    typedef enum logic [1:0] {StIdle, StClear, StPlace, StDone} state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [N-1:0]      map_q, map_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [REJ_W-1:0]  rej_q, rej_d;
    logic              clipped_q, clipped_d;
    logic              safe_vld_q, safe_vld_d;
    logic [IDX_W-1:0]  safe_idx_q, safe_idx_d;
    logic              busy_q, done_q;

    logic [IDX_W-1:0]  cand, fb_idx;
    logic              cand_ok, fb_found;
    logic [31:0]       req_ext, cap;

    assign lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign cand    = lfsr_q[IDX_W-1:0];
    assign cand_ok = (32'(cand) < N) && !map_q[cand] && !(safe_vld_q && (cand == safe_idx_q));
    assign req_ext = 32'(bomb_count);
    // One cell is always reserved when safe_en is set, even if the safe cell lies off the board.
    assign cap     = N - 32'(safe_en);

    // Fallback after too many rejections: lowest-index free, non-protected cell.
    always_comb begin
        fb_idx   = '0;
        fb_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!fb_found && !map_q[i] && !(safe_vld_q && (IDX_W'(i) == safe_idx_q))) begin
                fb_idx   = IDX_W'(i);
                fb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        cnt_d      = cnt_q;
        rej_d      = rej_q;
        target_d   = target_q;
        clipped_d  = clipped_q;
        safe_vld_d = safe_vld_q;
        safe_idx_d = safe_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    safe_vld_d = safe_en && (32'(safe_row) < ROWS) && (32'(safe_col) < COLS);
                    safe_idx_d = IDX_W'(32'(safe_row) * COLS + 32'(safe_col));
                    clipped_d  = req_ext > cap;
                    target_d   = (req_ext > cap) ? CNT_W'(cap) : bomb_count;
                    state_d    = StClear;
                end
            end
            StClear: begin
                map_d   = '0;
                cnt_d   = '0;
                rej_d   = '0;
                state_d = (target_q != '0) ? StPlace : StDone;
            end
            StPlace: begin
                if (rej_q == REJ_LIM) begin
                    map_d[fb_idx] = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    rej_d         = '0;
                end else if (cand_ok) begin
                    map_d[cand] = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    rej_d       = '0;
                end else begin
                    rej_d = rej_q + REJ_W'(1);
                end
                if (cnt_d == target_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            lfsr_q     <= SEED;
            map_q      <= '0;
            cnt_q      <= '0;
            rej_q      <= '0;
            target_q   <= '0;
            clipped_q  <= 1'b0;
            safe_vld_q <= 1'b0;
            safe_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            map_q      <= map_d;
            cnt_q      <= cnt_d;
            rej_q      <= rej_d;
            target_q   <= target_d;
            clipped_q  <= clipped_d;
            safe_vld_q <= safe_vld_d;
            safe_idx_q <= safe_idx_d;
            busy_q     <= (state_d == StClear) || (state_d == StPlace);
            done_q     <= (state_d == StDone);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign clipped      = clipped_q;
    assign bombs_placed = cnt_q;
    assign mine_map     = map_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: a per-run placement model predicts every output cycle by cycle,
// plus directed checks with literal expectations.
module tb_mine_placer;
    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int N       = ROWS * COLS;
    localparam int IDX_W   = 6;
    localparam int REJ_MAX = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  bomb_count = '0;
    logic        safe_en = 1'b0;
    logic [2:0]  safe_row = '0;
    logic [2:0]  safe_col = '0;
    logic        busy, done, clipped;
    logic [6:0]  bombs_placed;
    logic [63:0] mine_map;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;

    typedef struct {
        logic        busy;
        logic        done;
        logic [6:0]  cnt;
        logic [63:0] map;
        bit          sv;
        int          sidx;
    } exp_t;

    exp_t        plan[$];
    exp_t        e_now;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    logic        e_clipped = 1'b0;
    logic [6:0]  e_cnt = '0;
    logic [63:0] e_map = '0;
    bit          e_sv = 1'b0;
    int          e_sidx = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    mine_placer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bomb_count   (bomb_count),
        .safe_en      (safe_en),
        .safe_row     (safe_row),
        .safe_col     (safe_col),
        .busy         (busy),
        .done         (done),
        .clipped      (clipped),
        .bombs_placed (bombs_placed),
        .mine_map     (mine_map)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int lowest_free(input logic [63:0] m, input bit sv, input int sidx);
        for (int i = 0; i < N; i++) begin
            if (!m[i] && !(sv && i == sidx)) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole run predicted at the accepting edge; one entry per following clock edge.
    task automatic build_plan(input logic [15:0] l0);
        int req, cap, target, cnt, streak, idx, sidx;
        bit sv;
        logic [63:0] m;
        logic [15:0] l;
        exp_t e;
        req    = int'(bomb_count);
        cap    = N - (safe_en ? 1 : 0);
        target = (req > cap) ? cap : req;
        e_clipped = (req > cap);
        sv   = safe_en && (int'(safe_row) < ROWS) && (int'(safe_col) < COLS);
        sidx = int'(safe_row) * COLS + int'(safe_col);
        e.busy = 1'b1; e.done = 1'b0; e.cnt = e_cnt; e.map = e_map; e.sv = 1'b0; e.sidx = 0;
        plan.push_back(e);
        e.busy = (target != 0); e.done = (target == 0); e.cnt = '0; e.map = '0;
        e.sv = sv; e.sidx = sidx;
        plan.push_back(e);
        l = lfsr_next(lfsr_next(l0));
        m = '0;
        cnt = 0;
        streak = 0;
        while (cnt < target) begin
            if (streak == REJ_MAX) begin
                idx = lowest_free(m, sv, sidx);
                m[idx] = 1'b1;
                cnt++;
                streak = 0;
            end else begin
                idx = int'(l) % (1 << IDX_W);
                if (idx < N && !m[idx] && !(sv && idx == sidx)) begin
                    m[idx] = 1'b1;
                    cnt++;
                    streak = 0;
                end else begin
                    streak++;
                end
            end
            l = lfsr_next(l);
            e.busy = (cnt != target); e.done = (cnt == target); e.cnt = 7'(cnt); e.map = m;
            plan.push_back(e);
        end
        e.busy = 1'b0; e.done = 1'b0;
        plan.push_back(e);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr = 16'hACE1;
            plan.delete();
            e_busy = 1'b0; e_done = 1'b0; e_clipped = 1'b0;
            e_cnt = '0; e_map = '0; e_sv = 1'b0; e_sidx = 0;
        end else begin
            if (plan.size() == 0 && start) build_plan(m_lfsr);
            m_lfsr = lfsr_next(m_lfsr);
            if (plan.size() != 0) begin
                e_now  = plan.pop_front();
                e_busy = e_now.busy;
                e_done = e_now.done;
                e_cnt  = e_now.cnt;
                e_map  = e_now.map;
                e_sv   = e_now.sv;
                e_sidx = e_now.sidx;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("clipped", 64'(clipped), 64'(e_clipped));
        check("bombs_placed", 64'(bombs_placed), 64'(e_cnt));
        check("mine_map", mine_map, e_map);
        check("popcount", 64'($countones(mine_map)), 64'(e_cnt));
        if (e_sv) check("safe_cell", 64'(mine_map[e_sidx]), 64'd0);
        if (done) done_seen++;
    end

    task automatic do_start(input int bc, input bit se, input int r, input int c);
        @(posedge clk); #1;
        bomb_count = 7'(bc);
        safe_en    = se;
        safe_row   = 3'(r);
        safe_col   = 3'(c);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int cyc;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        logic [63:0] map_a, map_b;
        int d0;

        // T1: reset
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t1_map", mine_map, 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_done", 64'(done), 64'd0);
        check("t1_cnt", 64'(bombs_placed), 64'd0);
        check("t1_clipped", 64'(clipped), 64'd0);

        // T2: 10 mines, safe (3,4) = bit 28
        do_start(10, 1'b1, 3, 4);
        wait_done(172, "t2_done_in_time");
        check("t2_pop", 64'($countones(mine_map)), 64'd10);
        check("t2_bit28", 64'(mine_map[28]), 64'd0);
        check("t2_cnt", 64'(bombs_placed), 64'd10);
        check("t2_clipped", 64'(clipped), 64'd0);

        // T3: over-capacity request
        repeat (3) @(posedge clk);
        do_start(70, 1'b1, 0, 0);
        wait_done(1100, "t3_done_in_time");
        check("t3_map", mine_map, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3_cnt", 64'(bombs_placed), 64'd63);
        check("t3_clipped", 64'(clipped), 64'd1);

        // T4: zero mines, done two cycles after start
        do_start(0, 1'b0, 0, 0);
        @(negedge clk);
        check("t4_busy_t1", 64'(busy), 64'd1);
        check("t4_done_t1", 64'(done), 64'd0);
        @(negedge clk);
        check("t4_done_t2", 64'(done), 64'd1);
        check("t4_busy_t2", 64'(busy), 64'd0);
        check("t4_map", mine_map, 64'd0);
        check("t4_clipped", 64'(clipped), 64'd0);
        @(negedge clk);
        check("t4_done_t3", 64'(done), 64'd0);

        // T5: start while busy ignored; reset mid-PLACE
        d0 = done_seen;
        do_start(10, 1'b1, 3, 4);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(172, "t5_done_in_time");
        repeat (4) @(negedge clk);
        check("t5_single_done", 64'(done_seen - d0), 64'd1);
        do_start(10, 1'b1, 3, 4);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_rst_map", mine_map, 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_cnt", 64'(bombs_placed), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        do_start(10, 1'b0, 0, 0);
        wait_done(172, "t5_fresh_done");
        check("t5_fresh_pop", 64'($countones(mine_map)), 64'd10);

        // T6: two runs at different start times
        repeat (5) @(posedge clk);
        do_start(10, 1'b1, 3, 4);
        wait_done(172, "t6a_done");
        check("t6a_pop", 64'($countones(mine_map)), 64'd10);
        check("t6a_bit28", 64'(mine_map[28]), 64'd0);
        map_a = mine_map;
        repeat (13) @(posedge clk);
        do_start(10, 1'b1, 3, 4);
        wait_done(172, "t6b_done");
        check("t6b_pop", 64'($countones(mine_map)), 64'd10);
        check("t6b_bit28", 64'(mine_map[28]), 64'd0);
        map_b = mine_map;
        check("t6_maps_differ", 64'(map_a != map_b), 64'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
